// File: rtl/pe_cluster_pkg.sv
// pe_cluster_pkg -- shared constants and helpers for the PE cluster.
//   * Parameter defaults for the cluster (PE count, lanes, accumulator width).
//   * INT8_MAX / INT8_MIN output saturation bounds.
//   * requant(): round-half-up right shift, optional ReLU, int8 saturation.
//     The accumulator is passed sign-extended to ACC_W_MAX bits, so every
//     cluster instance must use ACC_W <= ACC_W_MAX.
package pe_cluster_pkg;

  localparam int NUM_PE_DEF = 16;
  localparam int LANES_DEF  = 4;
  localparam int ACC_W_DEF  = 24;
  localparam int ACC_W_MAX  = 32;

  localparam logic signed [7:0] INT8_MAX = 8'sh7F;
  localparam logic signed [7:0] INT8_MIN = 8'sh80;

  function automatic logic [7:0] requant(input logic signed [ACC_W_MAX-1:0] acc,
                                         input logic [3:0]                  shift,
                                         input logic                        relu_en);
    // One guard bit so the rounding add cannot overflow.
    logic signed [ACC_W_MAX:0] t;
    logic signed [ACC_W_MAX:0] one;
    logic signed [ACC_W_MAX:0] hi;
    logic signed [ACC_W_MAX:0] lo;
    logic [7:0]                res;
    one = {{ACC_W_MAX{1'b0}}, 1'b1};
    hi  = {{(ACC_W_MAX-7){INT8_MAX[7]}}, INT8_MAX};
    lo  = {{(ACC_W_MAX-7){INT8_MIN[7]}}, INT8_MIN};
    t   = {acc[ACC_W_MAX-1], acc};
    if (shift != 4'd0) t = t + (one <<< (shift - 4'd1));
    t = t >>> shift;
    if (relu_en && t[ACC_W_MAX]) t = '0;
    if (t > hi)      res = INT8_MAX;
    else if (t < lo) res = INT8_MIN;
    else             res = t[7:0];
    return res;
  endfunction

endpackage

// File: rtl/pe_cluster_param_if.sv
// pe_cluster_param_if -- beat input / result output bundle of the PE cluster.
//   master : beat source and result sink (drives in_*, ifm, weight, pe_en,
//            shift, relu_en, out_ready).
//   slave  : the cluster (drives in_ready, ofm, ofm_mask, ofm_valid).
// Handshake: a beat transfers on a rising edge where in_valid && in_ready; a
// result transfers on a rising edge where ofm_valid && out_ready. While a
// valid is high without its ready, the payload it qualifies stays stable.
interface pe_cluster_param_if
  import pe_cluster_pkg::*;
#(
  parameter int NUM_PE = NUM_PE_DEF,
  parameter int LANES  = LANES_DEF
);
  logic                      in_valid;
  logic                      in_ready;
  logic                      in_first;
  logic                      in_last;
  logic [LANES*8-1:0]        ifm;
  logic [NUM_PE*LANES*8-1:0] weight;
  logic [NUM_PE-1:0]         pe_en;
  logic [3:0]                shift;
  logic                      relu_en;
  logic [NUM_PE*8-1:0]       ofm;
  logic [NUM_PE-1:0]         ofm_mask;
  logic                      ofm_valid;
  logic                      out_ready;

  modport master (
    output in_valid, in_first, in_last, ifm, weight, pe_en, shift, relu_en, out_ready,
    input  in_ready, ofm, ofm_mask, ofm_valid
  );

  modport slave (
    input  in_valid, in_first, in_last, ifm, weight, pe_en, shift, relu_en, out_ready,
    output in_ready, ofm, ofm_mask, ofm_valid
  );
endinterface

// File: rtl/pe_mac_lane.sv
// pe_mac_lane -- one processing element of the cluster.
//   S1: registers the signed int8 dot product of ifm and this PE's weights
//       (plus this PE's enable) when a beat is accepted.
//   S2: saturating accumulate of the registered dot product; on a last beat
//       the requantised new accumulator value is loaded into the output reg.
// Ports: clk, reset_n (sync, active-high), accept (beat accepted this edge),
//   ifm / weight (LANES int8 lanes), en (accumulate enable), s1_* (shared S1
//   control from the top), ofm (int8 result), ofm_mask (enable of the tile).
module pe_mac_lane
  import pe_cluster_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               accept,
  input  logic [LANES*8-1:0] ifm,
  input  logic [LANES*8-1:0] weight,
  input  logic               en,
  input  logic               s1_valid,
  input  logic               s1_first,
  input  logic               s1_last,
  input  logic [3:0]         s1_shift,
  input  logic               s1_relu,
  output logic [7:0]         ofm,
  output logic               ofm_mask
);
  // One spare bit over the exact need keeps LANES=1 legal.
  localparam int DOT_W = 17 + $clog2(LANES);

  logic signed [DOT_W-1:0] dot_c;
  logic signed [DOT_W-1:0] dot_q;
  logic                    en_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_base;
  logic signed [ACC_W-1:0] acc_new;
  logic signed [ACC_W:0]   sum;
  logic [7:0]              ofm_q;
  logic                    mask_q;

  always_comb begin
    logic signed [15:0] prod;
    dot_c = '0;
    prod  = '0;
    for (int k = 0; k < LANES; k++) begin
      prod  = $signed(ifm[8*k +: 8]) * $signed(weight[8*k +: 8]);
      dot_c = dot_c + {{(DOT_W-16){prod[15]}}, prod};
    end
  end

  // Add in ACC_W+1 bits; a carry into the top bit that disagrees with the
  // sign bit means the true sum left the ACC_W range, so clamp to the bound.
  always_comb begin
    acc_base = s1_first ? '0 : acc_q;
    sum      = {acc_base[ACC_W-1], acc_base} + {{(ACC_W+1-DOT_W){dot_q[DOT_W-1]}}, dot_q};
    if (sum[ACC_W] != sum[ACC_W-1])
      acc_new = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      acc_new = sum[ACC_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      dot_q  <= '0;
      en_q   <= 1'b0;
      acc_q  <= '0;
      ofm_q  <= '0;
      mask_q <= 1'b0;
    end else begin
      if (accept) begin
        dot_q <= dot_c;
        en_q  <= en;
      end
      if (s1_valid) begin
        // A disabled PE still restarts on a first beat so it never carries
        // a stale sum into the next tile.
        if (en_q)          acc_q <= acc_new;
        else if (s1_first) acc_q <= '0;
        if (s1_last) begin
          mask_q <= en_q;
          ofm_q  <= en_q ? requant(ACC_W_MAX'(acc_new), s1_shift, s1_relu) : 8'h00;
        end
      end
    end
  end

  assign ofm      = ofm_q;
  assign ofm_mask = mask_q;
endmodule

// File: rtl/pe_cluster_param.sv
// pe_cluster_param -- NUM_PE int8 MAC processing elements sharing one IFM
// stream, with tile accumulation, requantisation and a held result register.
// Ports: clk (rising edge), reset_n (synchronous, active-high despite the
//   name), bus (pe_cluster_param_if slave: beat input, result output).
// Pipeline: accept edge -> S1 (dot products registered) -> next edge S2
//   (accumulate, result loaded on last beat). S2 never stalls: in_ready drops
//   while S1 holds a last beat or while an unaccepted result is held, so a
//   new result can only ever load into a free (or freeing) output register.
module pe_cluster_param
  import pe_cluster_pkg::*;
#(
  parameter int NUM_PE = NUM_PE_DEF,
  parameter int LANES  = LANES_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  pe_cluster_param_if.slave bus
);
  logic                accept;
  logic                s1_valid;
  logic                s1_first;
  logic                s1_last;
  logic [3:0]          s1_shift;
  logic                s1_relu;
  logic                load_result;
  logic                ofm_valid_q;
  logic [NUM_PE*8-1:0] ofm_w;
  logic [NUM_PE-1:0]   mask_w;

  assign load_result  = s1_valid && s1_last;
  assign bus.in_ready = !load_result && !(ofm_valid_q && !bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (reset_n) begin
      s1_valid    <= 1'b0;
      s1_first    <= 1'b0;
      s1_last     <= 1'b0;
      s1_shift    <= '0;
      s1_relu     <= 1'b0;
      ofm_valid_q <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_first <= bus.in_first;
        s1_last  <= bus.in_last;
        s1_shift <= bus.shift;
        s1_relu  <= bus.relu_en;
      end
      // A loading result wins over a same-edge handshake of the old one.
      if (load_result)        ofm_valid_q <= 1'b1;
      else if (bus.out_ready) ofm_valid_q <= 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_PE; i++) begin : g_pe
    pe_mac_lane #(
      .LANES (LANES),
      .ACC_W (ACC_W)
    ) u_pe (
      .clk      (clk),
      .reset_n  (reset_n),
      .accept   (accept),
      .ifm      (bus.ifm),
      .weight   (bus.weight[i*LANES*8 +: LANES*8]),
      .en       (bus.pe_en[i]),
      .s1_valid (s1_valid),
      .s1_first (s1_first),
      .s1_last  (s1_last),
      .s1_shift (s1_shift),
      .s1_relu  (s1_relu),
      .ofm      (ofm_w[i*8 +: 8]),
      .ofm_mask (mask_w[i])
    );
  end

  assign bus.ofm       = ofm_w;
  assign bus.ofm_mask  = mask_w;
  assign bus.ofm_valid = ofm_valid_q;
endmodule

// File: doc/pe_cluster_param.md
PE_CLUSTER_PARAM -- requirements
Module: pe_cluster_param

Interface
REQ-001 SHALL have parameter NUM_PE, 16, number of PEs.
REQ-002 SHALL have parameter LANES, 4, int8 lanes per IFM/weight word.
REQ-003 SHALL have parameter ACC_W, 24, signed accumulator width (min 16+clog2(LANES)).
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port reset_n  in  1  reset, synchronous and active-high (asserted at 1; codebase port name).
REQ-006 SHALL have port in_valid  in  1  input beat valid.
REQ-007 SHALL have port in_ready  out  1  input beat accepted when in_valid&in_ready.
REQ-008 SHALL have port in_first  in  1  beat starts a tile (accumulator restarts).
REQ-009 SHALL have port in_last  in  1  beat ends a tile (result emitted).
REQ-010 SHALL have port ifm  in  LANES*8  shared signed int8 lanes, lane k = bits [8k+7:8k].
REQ-011 SHALL have port weight  in  NUM_PE*LANES*8  per-PE signed int8 lanes, PE i at slice i.
REQ-012 SHALL have port pe_en  in  NUM_PE  per-PE accumulate enable.
REQ-013 SHALL have port shift  in  4  requant right shift, sampled with last beat.
REQ-014 SHALL have port relu_en  in  1  clamp negatives to 0, sampled with last beat.
REQ-015 SHALL have port ofm  out  NUM_PE*8  signed int8 results, PE i at slice i.
REQ-016 SHALL have port ofm_mask  out  NUM_PE  pe_en captured with last beat.
REQ-017 SHALL have port ofm_valid  out  1  result held until ofm_valid&out_ready.
REQ-018 SHALL have port out_ready  in  1  downstream accepts result.

Function
REQ-019 Stage S1 SHALL register, per PE, dot = sum over lanes of signed ifm*weight, plus first/last/shift/relu/pe_en, one cycle after acceptance.
REQ-020 Stage S2 SHALL update acc_i <= (first ? 0 : acc_i) + dot_i when pe_en_i, else hold acc_i (first with pe_en_i=0 clears to 0).
REQ-021 Accumulation SHALL saturate at signed ACC_W bounds, never wrap.
REQ-022 On a last beat in S2, ofm_i SHALL load requant(new acc_i) and ofm_valid SHALL rise; latency accept-edge to ofm_valid = 2 cycles.
REQ-023 requant SHALL be: add 1<<(shift-1) if shift>0, arithmetic shift right, ReLU if relu_en, saturate to [-128,127].
REQ-024 ofm_i SHALL be 0 where captured ofm_mask_i=0.
REQ-025 in_ready SHALL be !(S1 holds last) && !(ofm_valid && !out_ready); pipeline never stalls.
REQ-026 ofm, ofm_mask SHALL stay stable while ofm_valid&!out_ready; ofm_valid clears on handshake unless a new result loads same edge.
REQ-027 A beat with in_first and in_last both set SHALL form a one-beat tile.
REQ-028 Beats with in_valid&!in_ready SHALL be ignored (no state change).

Reset
REQ-029 While reset_n=1 at a rising edge: acc, S1 regs, ofm, ofm_mask, ofm_valid SHALL clear to 0; in_ready SHALL be 1 the cycle after release.
REQ-030 Reset mid-tile or with ofm_valid high SHALL discard all in-flight and held results.

Structure
REQ-031 Package pe_cluster_pkg SHALL hold parameter defaults, INT8_MAX/INT8_MIN, and the requant function.
REQ-032 One PE (S1 dot, S2 acc, requant, output reg) SHALL be sub-module pe_mac_lane, instantiated NUM_PE times by generate; handshake logic lives in the top.

Verification
REQ-033 Reset: assert reset_n 2 cycles -> ofm=0, ofm_valid=0, ofm_mask=0, then in_ready=1.
REQ-034 One-beat tile: ifm=0x01020304, all weights 0x01010101, pe_en=0xFFFF, shift=0 -> 2 cycles later every ofm byte 0x0A, ofm_mask=0xFFFF.
REQ-035 Saturation: 20 beats ifm=weights=0x7F7F7F7F, shift=4 -> all 0x7F; weights 0x81818181 -> 0x80 with relu_en=0, 0x00 with relu_en=1.
REQ-036 Rounding: acc 10 (REQ-034 stimulus), shift=2 -> 0x03; shift=1 -> 0x05; acc -10 shift=2 -> 0xFE.
REQ-037 Backpressure: out_ready=0 after tile, send second tile -> in_ready=0, ofm stable; out_ready=1 -> second result 2 cycles after its acceptance, none lost.
REQ-038 Mask and reset: pe_en=0x0001 -> only ofm[0] nonzero, ofm_mask=0x0001; reset between first and last -> no ofm_valid for that tile.
